reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor of the CPU integer register file.
- Provides NUM_RD asynchronous read ports and two synchronous write ports.
- x0 is hardwired to zero when ZERO_REG=1.
- Adds a self-clearing reset sequencer and deterministic write-port collision handling.
- Sits in the decode/writeback stage of the RISC-V pipeline. Port 0 carries the ALU writeback; port 1 carries the load/late writeback.

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers; power of two, >= 2
AW, $clog2(DEPTH), address width (derived, not overridden)
NUM_RD, 2, number of read ports, 1..4
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
ra  in  NUM_RD*AW  read addresses; port k at bits [k*AW +: AW]
rd  out  NUM_RD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
ready  out  1  high when the clear sequence is done and writes are accepted
collide  out  1  registered flag: previous cycle had both ports writing the same address

Behaviour:
- Reset: rst is synchronous and active-high, and is sampled only on the clk rising edge.
- FSM states are CLEAR and RUN.
- While rst=1, the FSM is forced to CLEAR, the clear index clr_idx=0, ready=0 and collide=0.
- Reset is always honoured. Asserting rst mid-CLEAR or mid-RUN restarts the sweep at index 0.
- CLEAR state:
  - Each cycle with rst=0 writes 0 to entry clr_idx, then increments clr_idx.
  - When clr_idx==DEPTH-1 has been cleared, the FSM moves to RUN. ready rises on the next cycle, exactly DEPTH cycles after rst deasserts.
  - we0/we1 are ignored.
  - All rd ports read 0.
- RUN state:
  - ready=1.
  - A write on port p commits at the rising edge when we_p=1, unless ZERO_REG=1 and wa_p==0.
- Same-address write collision (we0=we1=1, wa0==wa1):
  - Port 1 wins and wd0 is discarded.
  - collide=1 for exactly one cycle after the edge. This applies even for address 0.
- Writes to different addresses commit in the same cycle.
- Reads:
  - Combinational from the stored array with zero latency; rd_k reflects ra_k after settling.
  - A read of the address being written returns the old value until the edge (no bypass unless the optional feature is enabled).
  - If ZERO_REG=1, ra_k==0 always yields 0.
- Storage is not cleared at time 0. Contents are undefined until the first reset sweep completes. The bench must reset first.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in RUN, if any enabled write targets ra_k (excluding x0 when ZERO_REG=1), rd_k returns the incoming data combinationally in the same cycle. Port 1 data takes priority on collision. In CLEAR, reads still return 0.
- Undefined: reads return the stored value only; the new value is visible the cycle after the write edge.

Test Plan:
1. Hold rst=1 for 2 cycles, release. Check ready=0 for 32 cycles and 1 on cycle 33. Check all 32x32 (ra0,ra1) pairs read 0.
2. RUN: we0=1, wa0=3, wd0=12, ra0=3. After the edge rd0=12. Then we0=0, wd0=25: rd0 stays 12. ra1=3 gives rd1=12.
3. we0=1, wa0=0, wd0=100. After the edge rd0 at ra0=0 is 0 (ZERO_REG=1). Repeat with port 1: still 0.
4. we0=we1=1, wa0=wa1=7, wd0=0xAAAA_AAAA, wd1=0x5555_5555. rd at 7 is 0x5555_5555; collide=1 for one cycle, then 0. Then wa0=8, wa1=9: both written, collide=0.
5. Write 0xDEAD_BEEF to x5, then assert rst for 1 cycle at clr_idx=10 of a fresh sweep and again in RUN. ready drops, the sweep restarts, and after 32 cycles x5 reads 0. Writes issued during CLEAR have no effect.
6. With REGFILE_WRITE_BYPASS_EN: we0=1, wa0=4, wd0=0x1234, ra0=4. rd0=0x1234 before the edge. Without the macro, rd0 reads the old value (0) until the edge.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file.
// NUM_RD combinational read ports, two synchronous write ports (port 1 wins on
// a same-address collision) and a self-clearing sweep after reset.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN. When it is defined, reads
// forward write data in the same cycle. When it is undefined, reads return
// stored data only.

module reg_file_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   ra,
    output logic [NUM_RD*XLEN-1:0] rd,
    input  logic                   we0,
    input  logic [AW-1:0]          wa0,
    input  logic [XLEN-1:0]        wd0,
    input  logic                   we1,
    input  logic [AW-1:0]          wa1,
    input  logic [XLEN-1:0]        wd1,
    output logic                   ready,
    output logic                   collide
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            collide_q, collide_d;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];

    logic run;
    logic same_addr;
    logic wr0_ok, wr1_ok;
    logic commit0, commit1;

    // Decode the write requests. Port 1 has priority when both ports target the same entry.
    always_comb begin
        run       = (state_q == StRun);
        same_addr = we0 && we1 && (wa0 == wa1);
        wr0_ok    = run && we0 && !(ZERO_REG && (wa0 == '0));
        wr1_ok    = run && we1 && !(ZERO_REG && (wa1 == '0));
        commit0   = wr0_ok && !same_addr && !rst;
        commit1   = wr1_ok && !rst;
    end

    // Next state for the sequencer: sweep every entry once, then accept writes.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        collide_d = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // The flag also fires for x0, even though neither write lands there.
                collide_d = same_addr;
            end
        endcase
    end

    // Sequencer state. A synchronous reset restarts the sweep from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            collide_q <= collide_d;
        end
    end

    // Storage next state. In CLEAR, the sweep write is the only write. In RUN, the decoded port writes are applied.
    always_comb begin
        mem_d = mem_q;
        if (!rst && (state_q == StClear)) begin
            mem_d[clr_idx_q] = '0;
        end else begin
            if (commit0) begin
                mem_d[wa0] = wd0;
            end
            if (commit1) begin
                mem_d[wa1] = wd1;
            end
        end
    end

    // Storage array. It has no reset; the sweep gives it defined contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Each read port is combinational. During CLEAR it returns 0, and x0 returns 0 when ZERO_REG is set.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   ra_k;
        logic [XLEN-1:0] rd_k;

        assign ra_k = ra[k*AW +: AW];

        // Read mux for port k.
        always_comb begin
            rd_k = mem_q[ra_k];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wr1_ok && (wa1 == ra_k)) begin
                rd_k = wd1;
            end else if (wr0_ok && (wa0 == ra_k)) begin
                rd_k = wd0;
            end
`endif
            if (!run || (ZERO_REG && (ra_k == '0))) begin
                rd_k = '0;
            end
        end

        assign rd[k*XLEN +: XLEN] = rd_k;
    end

    assign ready   = run;
    assign collide = collide_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed testbench for reg_file_mp with the default parameters.
// Expected values are computed by hand in this file.

module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [4:0]  ra0_s, ra1_s;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ready, collide;

    int unsigned n_tests;
    int unsigned n_failed;

    assign ra = {ra1_s, ra0_s};

    reg_file_mp dut (
        .clk     (clk),
        .rst     (rst),
        .ra      (ra),
        .rd      (rd),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .ready   (ready),
        .collide (collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_and_sweep(input string tag);
        rst = 1'b0;
        for (int i = 0; i < 31; i++) begin
            step();
            check_eq({tag, "_ready_low"}, 32'(ready), 32'd0);
        end
        step();
        check_eq({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [31:0] bypass_exp;
        n_tests  = 0;
        n_failed = 0;
        rst = 1'b1; ra0_s = '0; ra1_s = '0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;

        // 1: reset, sweep timing and all-zero contents
        step();
        step();
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_collide", 32'(collide), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_eq("sweep_ready_low", 32'(ready), 32'd0);
            step();
        end
        check_eq("sweep_ready_high", 32'(ready), 32'd1);
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                ra0_s = 5'(a);
                ra1_s = 5'(b);
                #1;
                check_eq("zero_rd0", rd[31:0], 32'd0);
                check_eq("zero_rd1", rd[63:32], 32'd0);
            end
        end
        step();

        // 2: basic write and hold
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'd12; ra0_s = 5'd3;
        step();
        check_eq("wr3_rd0", rd[31:0], 32'd12);
        we0 = 1'b0; wd0 = 32'd25;
        step();
        check_eq("hold3_rd0", rd[31:0], 32'd12);
        ra1_s = 5'd3;
        #1;
        check_eq("wr3_rd1", rd[63:32], 32'd12);

        // 3: x0 ignores writes from either port
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'd100; ra0_s = 5'd0;
        step();
        we0 = 1'b0;
        check_eq("x0_port0", rd[31:0], 32'd0);
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'd100;
        step();
        we1 = 1'b0;
        check_eq("x0_port1", rd[31:0], 32'd0);

        // 4: collisions
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_AAAA;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555_5555;
        ra0_s = 5'd7;
        step();
        we0 = 1'b0; we1 = 1'b0;
        check_eq("coll_data", rd[31:0], 32'h5555_5555);
        check_eq("coll_flag", 32'(collide), 32'd1);
        step();
        check_eq("coll_clear", 32'(collide), 32'd0);
        check_eq("coll_keep", rd[31:0], 32'h5555_5555);
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h0000_0808;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h0000_0909;
        step();
        we0 = 1'b0; we1 = 1'b0;
        ra0_s = 5'd8; ra1_s = 5'd9;
        #1;
        check_eq("dual_flag", 32'(collide), 32'd0);
        check_eq("dual_rd8", rd[31:0], 32'h0000_0808);
        check_eq("dual_rd9", rd[63:32], 32'h0000_0909);
        we0 = 1'b1; wa0 = 5'd0; we1 = 1'b1; wa1 = 5'd0;
        step();
        we0 = 1'b0; we1 = 1'b0;
        check_eq("coll_x0_flag", 32'(collide), 32'd1);

        // 6: same-cycle visibility of a write
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_1234; ra0_s = 5'd4;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        bypass_exp = 32'h0000_1234;
`else
        bypass_exp = 32'd0;
`endif
        check_eq("bypass_pre", rd[31:0], bypass_exp);
        step();
        we0 = 1'b0;
        check_eq("bypass_post", rd[31:0], 32'h0000_1234);

        // 5: reset mid-sweep and in RUN; writes during CLEAR are dropped
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra0_s = 5'd5;
        step();
        we0 = 1'b0;
        check_eq("x5_written", rd[31:0], 32'hDEAD_BEEF);
        rst = 1'b1;
        step();
        check_eq("rst_run_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        check_eq("rst_mid_ready", 32'(ready), 32'd0);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h2222_2222;
        check_eq("clear_rd_zero", rd[31:0], 32'd0);
        release_and_sweep("resweep");
        we0 = 1'b0; we1 = 1'b0;
        ra0_s = 5'd5; ra1_s = 5'd6;
        #1;
        check_eq("x5_cleared", rd[31:0], 32'd0);
        check_eq("x6_no_clear_wr", rd[63:32], 32'd0);
        ra0_s = 5'd7;
        #1;
        check_eq("x7_cleared", rd[31:0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
